// File: rtl/stream_cipher_pkg.sv
// Shared types, constants and bit-permutation helpers for the stream cipher.
// Latency: none (package only).
// Backpressure: n/a.
package stream_cipher_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_e;

  // Bit permutation: out bit i takes in bit (PERM_MUL*i + PERM_OFF) mod width.
  // This is a bijection only while width is not a multiple of PERM_MUL.
  localparam int PERM_MUL = 3;
  localparam int PERM_OFF = 1;

  // Power-up key for the 8-bit x 3-word build. Wider or deeper builds take
  // the low bits of the same 24-bit pattern repeated.
  localparam logic [23:0]  DEF_KEY     = 24'h3CC3A5;
  localparam logic [263:0] DEF_KEY_REP = {11{DEF_KEY}};

  // Forward permutation on the low w bits of x (w <= 32); upper bits are 0.
  function automatic logic [31:0] perm(input logic [31:0] x, input int w);
    logic [31:0] y;
    int          src;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        src          = (PERM_MUL * i + PERM_OFF) % w;
        y[5'(i)]     = x[5'(src)];
      end
    end
    return y;
  endfunction

  // Exact inverse of perm for the same width.
  function automatic logic [31:0] perm_inv(input logic [31:0] x, input int w);
    logic [31:0] y;
    int          dst;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        dst          = (PERM_MUL * i + PERM_OFF) % w;
        y[5'(dst)]   = x[5'(i)];
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/stream_cipher_if.sv
// Valid/ready word channel used on both sides of the stream cipher.
// Latency: none (wires only).
// Backpressure: transfer happens on a cycle where valid && ready.
// Ports: valid/data driven by the master, ready driven by the slave.
interface stream_cipher_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_cipher_key_rot.sv
// Rotating key register: holds KEY_WORDS words, presents word 0 as the active key.
// Latency: load/rotate take effect on the edge they are requested.
// Backpressure: none; adv must only pulse for words actually accepted.
// Ports: clk, rst (async active-low), load/key_in (replace key, clear count),
//        adv (one accepted word), key_word (current key word 0).
module stream_cipher_key_rot
  import stream_cipher_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int KEY_WORDS  = 3,
  parameter int ROT_PERIOD = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [DATA_W*KEY_WORDS-1:0] key_in,
  input  logic                        adv,
  output logic [DATA_W-1:0]           key_word
);

  localparam int                KEY_W    = DATA_W * KEY_WORDS;
  localparam logic [KEY_W-1:0]  RST_KEY  = DEF_KEY_REP[KEY_W-1:0];
  localparam logic [7:0]        ROT_LAST = 8'(ROT_PERIOD - 1);

  logic [KEY_W-1:0] key_q;
  logic [7:0]       rot_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q   <= RST_KEY;
      rot_cnt <= '0;
    end else if (load) begin
      key_q   <= key_in;
      rot_cnt <= '0;
    end else if (adv) begin
      if (rot_cnt == ROT_LAST) begin
        rot_cnt <= '0;
        // Rotate left by one word: the top word becomes the new word 0.
        key_q   <= {key_q[KEY_W-DATA_W-1:0], key_q[KEY_W-1 -: DATA_W]};
      end else begin
        rot_cnt <= rot_cnt + 8'd1;
      end
    end
  end

  assign key_word = key_q[DATA_W-1:0];

endmodule

// File: rtl/stream_cipher_unit.sv
// Permute-and-XOR stream cipher with runtime key/mode load behind a drain FSM.
// Latency: 1 cycle from input acceptance to out valid; one word per cycle.
// Backpressure: in ready only when RUN, no key_load, and output slot free or draining.
// Ports: clk, rst (async active-low), key_load/key_in/mode (key request),
//        in_if (slave, words in), out_if (master, words out), key_busy (DRAIN/LOAD).
// Optional: define WORD_CNT_EN to add word_cnt[15:0], a saturating count of
//           output handshakes cleared on reset and on key load.
// DATA_W must be 8, 16 or 32 so the permutation stays invertible.
module stream_cipher_unit
  import stream_cipher_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int KEY_WORDS  = 3,
  parameter int ROT_PERIOD = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_load,
  input  logic [DATA_W*KEY_WORDS-1:0] key_in,
  input  logic                        mode,
  stream_cipher_if.slave              in_if,
  stream_cipher_if.master             out_if,
  output logic                        key_busy
`ifdef WORD_CNT_EN
  ,
  output logic [15:0]                 word_cnt
`endif
);

  state_e            state;
  logic              mode_q;
  logic              in_rdy;
  logic              accept;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] key_word;
  logic [DATA_W-1:0] result;

  // key_load wins over a same-cycle input word so the load sees a clean boundary.
  assign in_rdy       = (state == RUN) && !key_load && (!out_valid_q || out_if.ready);
  assign accept       = in_if.valid && in_rdy;
  assign in_if.ready  = in_rdy;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;

  stream_cipher_key_rot #(
    .DATA_W     (DATA_W),
    .KEY_WORDS  (KEY_WORDS),
    .ROT_PERIOD (ROT_PERIOD)
  ) u_key_rot (
    .clk      (clk),
    .rst      (rst),
    .load     (state == LOAD),
    .key_in   (key_in),
    .adv      (accept),
    .key_word (key_word)
  );

  // Encrypt permutes then whitens; decrypt undoes both in reverse order.
  always_comb begin
    result = '0;
    if (mode_q) begin
      result = DATA_W'(perm_inv(32'(in_if.data ^ key_word), DATA_W));
    end else begin
      result = DATA_W'(perm(32'(in_if.data), DATA_W)) ^ key_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      key_busy <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (key_load) begin
            // A stalled output word must leave under the old key first.
            state    <= (out_valid_q && !out_if.ready) ? DRAIN : LOAD;
            key_busy <= 1'b1;
          end
        end
        DRAIN: begin
          if (!out_valid_q || out_if.ready) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          mode_q   <= mode;
          state    <= RUN;
          key_busy <= 1'b0;
        end
        default: begin
          state    <= RUN;
          key_busy <= 1'b0;
        end
      endcase
    end
  end

  // Output slot: load on accept, hold while stalled, otherwise empty and zeroed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= result;
    end else if (out_if.ready || !out_valid_q) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end
  end

`ifdef WORD_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (state == LOAD) begin
      word_cnt <= '0;
    end else if (out_valid_q && out_if.ready && (word_cnt != 16'hFFFF)) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_cipher_unit.sv
// Bench for stream_cipher_unit: instance 0 has ROT_PERIOD=1, instance 1 has ROT_PERIOD=3.
// A word-level model predicts every output; directed literals pin the model.
module tb_stream_cipher_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  key_load;
  logic [1:0]  mode;
  logic [1:0]  iv;
  logic [1:0]  ordy;
  logic [1:0]  ir;
  logic [1:0]  ov;
  logic [1:0]  kb;
  logic [23:0] key_in [2];
  logic [7:0]  idat   [2];
  logic [7:0]  od     [2];
`ifdef WORD_CNT_EN
  logic [15:0] wc     [2];
`endif

  stream_cipher_if #(.DATA_W(8)) in_a ();
  stream_cipher_if #(.DATA_W(8)) out_a ();
  stream_cipher_if #(.DATA_W(8)) in_b ();
  stream_cipher_if #(.DATA_W(8)) out_b ();

  assign in_a.valid  = iv[0];
  assign in_a.data   = idat[0];
  assign out_a.ready = ordy[0];
  assign ir[0]       = in_a.ready;
  assign ov[0]       = out_a.valid;
  assign od[0]       = out_a.data;
  assign in_b.valid  = iv[1];
  assign in_b.data   = idat[1];
  assign out_b.ready = ordy[1];
  assign ir[1]       = in_b.ready;
  assign ov[1]       = out_b.valid;
  assign od[1]       = out_b.data;

  stream_cipher_unit #(.DATA_W(8), .KEY_WORDS(3), .ROT_PERIOD(1)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load[0]),
    .key_in   (key_in[0]),
    .mode     (mode[0]),
    .in_if    (in_a),
    .out_if   (out_a),
    .key_busy (kb[0])
`ifdef WORD_CNT_EN
    ,
    .word_cnt (wc[0])
`endif
  );

  stream_cipher_unit #(.DATA_W(8), .KEY_WORDS(3), .ROT_PERIOD(3)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load[1]),
    .key_in   (key_in[1]),
    .mode     (mode[1]),
    .in_if    (in_b),
    .out_if   (out_b),
    .key_busy (kb[1])
`ifdef WORD_CNT_EN
    ,
    .word_cnt (wc[1])
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- word-level model ----------------
  // Source bit for each output bit of the 8-bit permutation, worked out by hand.
  int          src_tab [8] = '{1, 4, 7, 2, 5, 0, 3, 6};
  int          rot_per [2] = '{1, 3};
  logic [23:0] key_m   [2];
  logic        mode_m  [2];
  int          n_m     [2];
  logic [7:0]  expbuf  [2][64];
  int          wr_p    [2];
  int          rd_p    [2];

  // n-th word since load: after r = n/period rotations, word 0 is original word (3-r) mod 3.
  function automatic logic [7:0] model_word(input int k, input logic [7:0] x);
    int          idx;
    logic [23:0] sh;
    logic [7:0]  kw, z, y;
    idx = (3 - ((n_m[k] / rot_per[k]) % 3)) % 3;
    sh  = key_m[k] >> (8 * idx);
    kw  = sh[7:0];
    y   = '0;
    if (!mode_m[k]) begin
      for (int i = 0; i < 8; i++) y[3'(i)] = x[3'(src_tab[i])];
      y = y ^ kw;
    end else begin
      z = x ^ kw;
      for (int i = 0; i < 8; i++) y[3'(src_tab[i])] = z[3'(i)];
    end
    return y;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        key_m[k]  = 24'h3CC3A5;
        mode_m[k] = 1'b0;
        n_m[k]    = 0;
        wr_p[k]   = 0;
        rd_p[k]   = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ov[k]) begin
          if (rd_p[k] == wr_p[k]) begin
            check("model_unexpected_out_valid", 32'(ov[k]), 32'd0);
          end else begin
            check("model_out_data", 32'(od[k]), 32'(expbuf[k][rd_p[k]]));
            if (ordy[k]) rd_p[k] = (rd_p[k] + 1) % 64;
          end
        end else begin
          check("model_idle_out_data", 32'(od[k]), 32'd0);
          check("model_missing_out_valid", 32'(rd_p[k] != wr_p[k]), 32'd0);
        end
        check("model_in_ready_gate", 32'(ir[k] && (kb[k] || key_load[k])), 32'd0);
        if (key_load[k] && !kb[k]) begin
          key_m[k]  = key_in[k];
          mode_m[k] = mode[k];
          n_m[k]    = 0;
        end
        if (iv[k] && ir[k]) begin
          expbuf[k][wr_p[k]] = model_word(k, idat[k]);
          wr_p[k]            = (wr_p[k] + 1) % 64;
          n_m[k]++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] lit_enc  [4] = '{8'h85, 8'h1C, 8'hE3, 8'h85};
  logic [7:0] lit_rot3 [7] = '{8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'hC3};
  logic [7:0] lit_dec_in [3] = '{8'h85, 8'h1C, 8'hE3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    key_load  = '0;
    mode      = '0;
    iv        = '0;
    ordy      = '0;
    key_in[0] = '0;
    key_in[1] = '0;
    idat[0]   = '0;
    idat[1]   = '0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_out_valid", 32'(ov[k]), 32'd0);
      check("reset_out_data", 32'(od[k]), 32'd0);
      check("reset_key_busy", 32'(kb[k]), 32'd0);
`ifdef WORD_CNT_EN
      check("reset_word_cnt", 32'(wc[k]), 32'd0);
`endif
    end
    rst  = 1'b1;
    ordy = 2'b11;
    tick();

    // Encrypt 0x01 x4 with per-word rotation.
    iv[0] = 1'b1; idat[0] = 8'h01;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("enc_stream_valid", 32'(ov[0]), 32'd1);
      check("enc_stream_data", 32'(od[0]), 32'(lit_enc[j]));
    end
    iv[0] = 1'b0;
    tick();
    check("enc_drained_valid", 32'(ov[0]), 32'd0);
    check("enc_drained_data", 32'(od[0]), 32'd0);
`ifdef WORD_CNT_EN
    check("word_cnt_after_4", 32'(wc[0]), 32'd4);
`endif

    // Rotation every 3 words.
    iv[1] = 1'b1; idat[1] = 8'h00;
    for (int j = 0; j < 7; j++) begin
      tick();
      check("rot3_data", 32'(od[1]), 32'(lit_rot3[j]));
    end
    iv[1] = 1'b0;
    tick();

    // Output stall: word held, input blocked, key frozen.
    ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 8'h01;
    tick();
    check("stall_first_data", 32'(od[0]), 32'h1C);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("stall_hold_data", 32'(od[0]), 32'h1C);
      check("stall_hold_valid", 32'(ov[0]), 32'd1);
      check("stall_in_ready", 32'(ir[0]), 32'd0);
    end
    ordy[0] = 1'b1;
    tick();
    check("stall_resume_data", 32'(od[0]), 32'hE3);
    iv[0] = 1'b0;
    tick();
    check("stall_resume_empty", 32'(ov[0]), 32'd0);

    // Key load while output is stalled: DRAIN, then LOAD, then new key and decrypt.
    ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 8'h01;
    tick();
    check("pre_load_data", 32'(od[0]), 32'h85);
    iv[0] = 1'b0;
    key_in[0] = 24'h112233; mode[0] = 1'b1; key_load[0] = 1'b1;
    tick();
    check("drain_busy", 32'(kb[0]), 32'd1);
    key_load[0] = 1'b0;
    tick();
    check("drain_still_busy", 32'(kb[0]), 32'd1);
    check("drain_hold_data", 32'(od[0]), 32'h85);
    ordy[0] = 1'b1;
    tick();
    check("load_busy", 32'(kb[0]), 32'd1);
    check("load_out_empty", 32'(ov[0]), 32'd0);
    tick();
    check("run_after_load", 32'(kb[0]), 32'd0);
`ifdef WORD_CNT_EN
    check("word_cnt_after_load", 32'(wc[0]), 32'd0);
`endif
    iv[0] = 1'b1; idat[0] = 8'h13;
    tick();
    check("new_key_word0", 32'(od[0]), 32'h01);
    idat[0] = 8'h31;
    tick();
    check("new_key_word2", 32'(od[0]), 32'h01);
    iv[0] = 1'b0;
    tick();

    // Decrypt with the default key; key_load blocks a same-cycle word.
    key_in[0] = 24'h3CC3A5; mode[0] = 1'b1; key_load[0] = 1'b1;
    iv[0] = 1'b1; idat[0] = lit_dec_in[0];
    #1;
    check("key_load_priority", 32'(ir[0]), 32'd0);
    tick();
    key_load[0] = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      idat[0] = lit_dec_in[j];
      tick();
      check("dec_stream_data", 32'(od[0]), 32'h01);
    end
    iv[0] = 1'b0;
    tick();
    key_load[0] = 1'b1;
    tick();
    key_load[0] = 1'b0;
    tick();
    iv[0] = 1'b1; idat[0] = 8'hA1;
    tick();
    check("dec_first_word", 32'(od[0]), 32'h80);
    iv[0] = 1'b0;
    tick();

    // Asynchronous reset with a word pending.
    mode[0] = 1'b0; ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 8'h01;
    tick();
    check("pre_reset_valid", 32'(ov[0]), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_valid", 32'(ov[0]), 32'd0);
    check("async_reset_data", 32'(od[0]), 32'd0);
`ifdef WORD_CNT_EN
    check("async_reset_word_cnt", 32'(wc[0]), 32'd0);
`endif
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1; ordy[0] = 1'b1; iv[0] = 1'b1; idat[0] = 8'h00;
    tick();
    check("post_reset_key", 32'(od[0]), 32'hA5);
    iv[0] = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_cipher_unit.md
Name: stream_cipher_unit

Overview:
- Parametrised successor to the team's fixed 8-bit encryption block.
- Permute-and-XOR stream cipher with configurable word width, key depth and key-rotation period.
- Runtime encrypt/decrypt mode and runtime key load, both gated by a drain state machine.
- Valid/ready handshakes on input and output; sits between the byte/word source and the link framer.

Parameters:
DATA_W, 8, word width in bits; legal values 8, 16, 32 (must not be a multiple of 3)
KEY_WORDS, 3, number of DATA_W-bit key words in the rotating key register (range 2..8)
ROT_PERIOD, 1, accepted words per key rotation (range 1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
key_load  in  1  request to load key_in and mode
key_in  in  DATA_W*KEY_WORDS  new key; word 0 is the LSBs
mode  in  1  0 = encrypt, 1 = decrypt; sampled only at key load
in_valid  in  1  input word valid
in_data  in  DATA_W  input word
in_ready  out  1  input accepted when in_valid && in_ready
out_valid  out  1  output word valid
out_data  out  DATA_W  output word
out_ready  in  1  downstream accepts when out_valid && out_ready
key_busy  out  1  high in DRAIN and LOAD states

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid=0, out_data=0, key_busy=0.
  - key register = DEF_KEY, mode_q=0 (encrypt), rot_cnt=0, state=RUN.
  - Reset mid-stream discards the in-flight word; nothing is replayed.
- Permutation P: out bit i = in bit ((3*i+1) mod DATA_W). P_inv is its exact inverse.
- Datapath:
  - Encrypt: result = P(in_data) ^ key[DATA_W-1:0].
  - Decrypt: result = P_inv(in_data ^ key[DATA_W-1:0]).
- Output register with latency 1: word accepted at edge N appears with out_valid=1 after edge N.
- out_data/out_valid hold while out_valid && !out_ready. When no new word is accepted and the output is taken, out_valid=0 and out_data=0.
- in_ready = (state==RUN) && !key_load && (!out_valid || out_ready). Combinational; no skid buffer.
- Key rotation on each accepted word:
  - rot_cnt increments; when rot_cnt==ROT_PERIOD-1 it wraps to 0 and key rotates left by DATA_W bits (new word 0 = old word KEY_WORDS-1).
  - The word accepted in a cycle uses the pre-rotation key.
- State machine:
  - RUN: key_load=1 → DRAIN if out_valid && !out_ready, otherwise LOAD. key_load has priority over in_valid in the same cycle (no acceptance).
  - DRAIN: in_ready=0; → LOAD once the output handshake completes (or out_valid=0).
  - LOAD: one cycle; key←key_in, mode_q←mode, rot_cnt←0; → RUN. key_load does not need to be held after entry to DRAIN; key_in and mode must be held stable until LOAD.
- key_load asserted while in DRAIN/LOAD is ignored. A new request needs key_load high again in RUN.
- Encrypt and decrypt instances with identical parameters and key produce the identical key sequence, so decrypt(encrypt(x))==x word by word.

Optional Feature:
- Macro WORD_CNT_EN.
- Defined: adds output word_cnt [15:0], which counts output handshakes. It resets to 0 on rst and on LOAD, and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package stream_cipher_pkg holds:
  - state enum {RUN, DRAIN, LOAD}
  - DEF_KEY (24'h3CC3A5 for the DATA_W=8, KEY_WORDS=3 build; wider builds replicate it)
  - permutation multiplier/offset constants 3 and 1
  - functions perm/perm_inv parametrised on width
- One natural sub-module: stream_cipher_key_rot (key register, rot_cnt, load/rotate). The top keeps the FSM, datapath and output register.

Test Plan:
- Reset, encrypt, DATA_W=8, ROT_PERIOD=1, out_ready=1; send 0x01 x4 → out 0x85, 0x1C, 0xE3, 0x85 at one word per cycle.
- Decrypt instance with DEF_KEY; send 0x85, 0x1C, 0xE3 → 0x01, 0x01, 0x01. Send 0xA1 as the first word after reset → 0x80.
- out_ready=0 for 3 cycles with a word pending → out_data stable, in_ready=0, key does not rotate. Release → stream resumes with the correct key order.
- key_load while output stalled → DRAIN until out_ready, then LOAD. Next word uses key_in word 0 with rot_cnt=0; mode switch takes effect on that word.
- ROT_PERIOD=3, send 0x00 x7 → out A5, A5, A5, 3C, 3C, 3C, C3.
- Assert rst mid-stream with out_valid=1 → out_valid=0, out_data=0 immediately. First word after release uses key A5. With WORD_CNT_EN defined, word_cnt=0.
